// File: rtl/poker_frame_tx.sv
// Card-frame sender for the UART TX path: one request of 0..MAX_CARDS cards becomes
// HDR,type,count,cards[,checksum] (or the F0,F0,00 pass frame), handed to the UART byte by byte.
module poker_frame_tx #(
    parameter int         MAX_CARDS   = 8,
    parameter int         CNT_W       = 4,
    parameter logic [7:0] HDR_BYTE    = 8'hF3,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_type,
    input  logic [CNT_W-1:0]       req_count,
    input  logic [8*MAX_CARDS-1:0] req_cards,
    input  logic                   Tx_Done,
    output logic                   TxSendEnFlag,
    output logic [7:0]             TxDataByte,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   req_err
);

    localparam int               IDX_W   = 5;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CARDS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE} state_t;

    state_t           state;
    logic [7:0]       type_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       cards_q [MAX_CARDS];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] total;
    logic [IDX_W-1:0] card_idx;
    logic [7:0]       chk_q;
    logic [7:0]       card_byte;
    logic [7:0]       cur_byte;
    logic             done_d0;
    logic             done_d1;
    logic             tx_edge;
    logic             accept;

    function automatic logic [7:0] remap(input logic [7:0] b);
        case (b[7:4])
            4'hF:    return {4'h2, b[3:0]};
            4'hE:    return {4'h1, b[3:0]};
            default: return b;
        endcase
    endfunction

    assign accept  = req_valid && req_ready && (state == S_IDLE);
    assign tx_edge = done_d0 & ~done_d1;

    // NOTE: request payload is only read after a qualified capture, so these
    // storage flops carry no reset; control state below does.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            type_q  <= req_type;
            count_q <= req_count;
            for (int i = 0; i < MAX_CARDS; i++)
                cards_q[i] <= req_cards[8*i +: 8];
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        card_idx  = idx - IDX_W'(3);
        card_byte = 8'h00;
        for (int i = 0; i < MAX_CARDS; i++)
            if (card_idx == IDX_W'(i))
                card_byte = cards_q[i];
    end

    // Byte at position idx; the pass frame has no header and no checksum.
    always_comb begin
        cur_byte = 8'h00;
        if (count_q == '0)
            cur_byte = (idx < IDX_W'(2)) ? 8'hF0 : 8'h00;
        else if (idx == IDX_W'(0))
            cur_byte = HDR_BYTE;
        else if (idx == IDX_W'(1))
            cur_byte = type_q;
        else if (idx == IDX_W'(2))
            cur_byte = 8'(count_q);
        else if (CHECKSUM_EN && (idx == total - IDX_W'(1)))
            cur_byte = chk_q;
        else
            cur_byte = remap(card_byte);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            TxSendEnFlag <= 1'b0;
            TxDataByte   <= 8'h00;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            req_err      <= 1'b0;
            idx          <= '0;
            total        <= '0;
            chk_q        <= 8'h00;
            done_d0      <= 1'b0;
            done_d1      <= 1'b0;
        end else begin
            done_d0      <= Tx_Done;
            done_d1      <= done_d0;
            TxSendEnFlag <= 1'b0;
            frame_done   <= 1'b0;
            req_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (req_count > MAX_CNT) begin
                            req_err <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    idx   <= '0;
                    chk_q <= 8'h00;
                    total <= (count_q == '0) ? IDX_W'(3)
                           : IDX_W'(3) + IDX_W'(count_q) + IDX_W'(CHECKSUM_EN);
                    state <= S_SEND;
                end
                S_SEND: begin
                    TxDataByte   <= cur_byte;
                    TxSendEnFlag <= 1'b1;
                    chk_q        <= chk_q ^ cur_byte;
                    idx          <= idx + IDX_W'(1);
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_edge)
                        state <= (idx == total) ? S_DONE : S_SEND;
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poker_frame_tx.sv
// Directed bench for poker_frame_tx: a simple UART responder answers each send pulse with a
// Tx_Done level, and every transmitted byte is compared against hand-computed frames.
module tb_poker_frame_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        req_valid;
    logic        req_valid_nc;
    logic        req_ready;
    logic [7:0]  req_type;
    logic [3:0]  req_count;
    logic [63:0] req_cards;
    logic        Tx_Done;
    logic        TxSendEnFlag;
    logic [7:0]  TxDataByte;
    logic        busy;
    logic        frame_done;
    logic        req_err;

    logic        nc_req_ready;
    logic        nc_flag;
    logic [7:0]  nc_data;
    logic        nc_busy;
    logic        nc_frame_done;
    logic        nc_req_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          flag_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          served = 0;
    int          hold = 2;
    logic [7:0]  bytes_q[$];
    logic [7:0]  nc_bytes_q[$];
    logic [7:0]  want_q[$];

    always #5 sys_clk = ~sys_clk;

    poker_frame_tx #(.MAX_CARDS(8), .CNT_W(4), .HDR_BYTE(8'hF3), .CHECKSUM_EN(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_count(req_count), .req_cards(req_cards), .Tx_Done(Tx_Done),
        .TxSendEnFlag(TxSendEnFlag), .TxDataByte(TxDataByte), .busy(busy),
        .frame_done(frame_done), .req_err(req_err)
    );

    poker_frame_tx #(.MAX_CARDS(8), .CNT_W(4), .HDR_BYTE(8'hF3), .CHECKSUM_EN(1'b0)) dut_nc (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid_nc), .req_ready(nc_req_ready),
        .req_type(req_type), .req_count(req_count), .req_cards(req_cards), .Tx_Done(Tx_Done),
        .TxSendEnFlag(nc_flag), .TxDataByte(nc_data), .busy(nc_busy),
        .frame_done(nc_frame_done), .req_err(nc_req_err)
    );

    always @(negedge sys_clk) begin
        if (TxSendEnFlag) begin
            bytes_q.push_back(TxDataByte);
            flag_cnt = flag_cnt + 1;
        end
        if (nc_flag) nc_bytes_q.push_back(nc_data);
        if (frame_done) done_cnt = done_cnt + 1;
        if (req_err) err_cnt = err_cnt + 1;
    end

    // UART stand-in: each send pulse is answered by a Tx_Done level 'hold' cycles long.
    initial begin
        Tx_Done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (flag_cnt > served) begin
                served = served + 1;
                repeat (2) @(negedge sys_clk);
                Tx_Done = 1'b1;
                repeat (hold) @(negedge sys_clk);
                Tx_Done = 1'b0;
                repeat (2) @(negedge sys_clk);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec = n_vec + 1;
        assert (obs === want) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] got[$],
                               input logic [7:0] want[$]);
        check({tag, " length"}, 32'(got.size() - base), 32'(want.size()));
        for (int i = 0; i < want.size(); i++)
            if (base + i < got.size())
                check($sformatf("%s byte%0d", tag, i), 32'(got[base + i]), 32'(want[i]));
    endtask

    task automatic send_req(input logic [7:0] t, input logic [3:0] c, input logic [63:0] cards,
                            input logic to_nc);
        @(negedge sys_clk);
        req_type     = t;
        req_count    = c;
        req_cards    = cards;
        req_valid    = 1'b1;
        req_valid_nc = to_nc;
        @(negedge sys_clk);
        req_valid    = 1'b0;
        req_valid_nc = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        check({tag, " frame_done seen"}, 32'(done_cnt > start), 32'd1);
    endtask

    initial begin
        int base;
        int f0;
        int d0;
        int e0;
        int n;
        sys_rst_n    = 1'b0;
        req_valid    = 1'b0;
        req_valid_nc = 1'b0;
        req_type     = 8'h00;
        req_count    = 4'd0;
        req_cards    = 64'd0;
        repeat (3) @(negedge sys_clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset TxSendEnFlag", 32'(TxSendEnFlag), 32'd0);
        check("reset TxDataByte", 32'(TxDataByte), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset req_err", 32'(req_err), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single card, unused slots hold garbage that must not appear.
        base = bytes_q.size(); f0 = flag_cnt; d0 = done_cnt; e0 = err_cnt;
        send_req(8'h01, 4'd1, 64'hAAAA_AAAA_AAAA_AAF5, 1'b0);
        check("t1 busy after accept", 32'(busy), 32'd1);
        check("t1 req_ready after accept", 32'(req_ready), 32'd0);
        wait_done("t1", 300);
        want_q = '{8'hF3, 8'h01, 8'h01, 8'h25, 8'hD6};
        check_frame("t1", base, bytes_q, want_q);
        check("t1 send pulses", 32'(flag_cnt - f0), 32'd5);
        check("t1 frame_done count", 32'(done_cnt - d0), 32'd1);
        check("t1 req_err count", 32'(err_cnt - e0), 32'd0);
        @(negedge sys_clk);
        check("t1 req_ready back", 32'(req_ready), 32'd1);

        // Pair with E-high remap, with and without checksum.
        base = bytes_q.size(); n = nc_bytes_q.size();
        send_req(8'h02, 4'd2, 64'h5555_5555_5555_E7E7, 1'b1);
        wait_done("t2", 300);
        want_q = '{8'hF3, 8'h02, 8'h02, 8'h17, 8'h17, 8'hF3};
        check_frame("t2 chk", base, bytes_q, want_q);
        want_q = '{8'hF3, 8'h02, 8'h02, 8'h17, 8'h17};
        check_frame("t2 nochk", n, nc_bytes_q, want_q);
        repeat (5) @(negedge sys_clk);

        // Pass frame.
        base = bytes_q.size(); d0 = done_cnt; e0 = err_cnt;
        send_req(8'h01, 4'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        wait_done("t3", 300);
        want_q = '{8'hF0, 8'hF0, 8'h00};
        check_frame("t3", base, bytes_q, want_q);
        check("t3 frame_done count", 32'(done_cnt - d0), 32'd1);
        check("t3 req_err count", 32'(err_cnt - e0), 32'd0);
        repeat (5) @(negedge sys_clk);

        // Oversize request: rejected with a one-cycle error pulse.
        f0 = flag_cnt;
        send_req(8'h01, 4'd9, 64'h0, 1'b0);
        check("t4 req_err pulse", 32'(req_err), 32'd1);
        check("t4 busy", 32'(busy), 32'd0);
        check("t4 req_ready", 32'(req_ready), 32'd1);
        @(negedge sys_clk);
        check("t4 req_err drops", 32'(req_err), 32'd0);
        repeat (10) @(negedge sys_clk);
        check("t4 no send pulses", 32'(flag_cnt - f0), 32'd0);
        check("t4 busy later", 32'(busy), 32'd0);

        // Reset after the second byte aborts the frame.
        base = bytes_q.size();
        send_req(8'h01, 4'd1, 64'hF5, 1'b0);
        n = 0;
        while (bytes_q.size() < base + 2 && n < 200) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        check("t5 two bytes sent", 32'(bytes_q.size() - base), 32'd2);
        #1 sys_rst_n = 1'b0;
        #1;
        check("t5 rst TxSendEnFlag", 32'(TxSendEnFlag), 32'd0);
        check("t5 rst TxDataByte", 32'(TxDataByte), 32'd0);
        check("t5 rst busy", 32'(busy), 32'd0);
        check("t5 rst frame_done", 32'(frame_done), 32'd0);
        check("t5 rst req_err", 32'(req_err), 32'd0);
        check("t5 rst req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (15) @(negedge sys_clk);
        base = bytes_q.size();
        send_req(8'h01, 4'd1, 64'h33, 1'b0);
        wait_done("t5", 300);
        want_q = '{8'hF3, 8'h01, 8'h01, 8'h33, 8'hC0};
        check_frame("t5 restart", base, bytes_q, want_q);
        repeat (5) @(negedge sys_clk);

        // Tx_Done held high for 20 cycles; a second request mid-frame is ignored.
        hold = 20;
        base = bytes_q.size(); f0 = flag_cnt; d0 = done_cnt;
        send_req(8'h01, 4'd1, 64'hF5, 1'b0);
        repeat (30) @(negedge sys_clk);
        check("t6 busy mid-frame", 32'(busy), 32'd1);
        check("t6 req_ready mid-frame", 32'(req_ready), 32'd0);
        send_req(8'h02, 4'd1, 64'h33, 1'b0);
        wait_done("t6", 600);
        repeat (80) @(negedge sys_clk);
        want_q = '{8'hF3, 8'h01, 8'h01, 8'h25, 8'hD6};
        check_frame("t6", base, bytes_q, want_q);
        check("t6 send pulses", 32'(flag_cnt - f0), 32'd5);
        check("t6 frame_done count", 32'(done_cnt - d0), 32'd1);
        hold = 2;
        repeat (5) @(negedge sys_clk);

        // Full eight-card frame.
        base = bytes_q.size(); f0 = flag_cnt;
        send_req(8'h03, 4'd8, 64'h3837_3635_3433_3231, 1'b0);
        wait_done("t7", 600);
        want_q = '{8'hF3, 8'h03, 8'h08, 8'h31, 8'h32, 8'h33, 8'h34,
                   8'h35, 8'h36, 8'h37, 8'h38, 8'hF0};
        check_frame("t7", base, bytes_q, want_q);
        check("t7 send pulses", 32'(flag_cnt - f0), 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
